recon_val_reader: RTL and testbench
===================================

// Module: recon_val_reader
// PURPOSE
// - Read side of the tmp/val reconstruction store: after the spike accumulator pulses save_done, sweeps the
//   val memory read port (addr_q/ce0/q0) line 0..LINES-1 and streams the 8-bit window-size pixels out as frames.
// - Sits between the spike accumulator's read port and the downstream frame sink / DMA.
// - Prefetches lines into a 2-entry line buffer so the stream runs back-to-back under continuous m_ready.
// PARAMETERS
// - LINES        5000  lines per frame (addr_q range 0..LINES-1)
// - PIX_PER_LINE 50    pixels per memory line (q0 width = PIX_PER_LINE*PIX_W)
// - PIX_W        8     bits per pixel; pixel i of a line = q0[i*PIX_W +: PIX_W]
// - BEAT_PIX     5     pixels per output beat; PIX_PER_LINE % BEAT_PIX == 0 (10 beats/line at defaults)
// - RD_LAT       1     cycles from ce0 sampled high to q0 valid (1 or 2)
// PORTS
// - clk_200M     in   1    clock
// - rst_200M     in   1    synchronous reset, active-high
// - save_done    in   1    one-cycle pulse: val memory holds a complete frame
// - addr_q       out  13   read address to val memory
// - ce0          out  1    read enable to val memory
// - q0           in   400  read data, valid RD_LAT cycles after ce0
// - m_data       out  40   BEAT_PIX pixels, pixel 0 in bits [7:0]
// - m_valid      out  1    beat valid
// - m_ready      in   1    sink accepts beat when m_valid & m_ready
// - m_sof        out  1    high on first beat of frame (line 0, beat 0)
// - m_eol        out  1    high on last beat of each line
// - m_eof        out  1    high on last beat of frame (line LINES-1, last beat)
// - busy         out  1    high from accepted save_done until the m_eof beat is accepted
// - frame_drop   out  1    one-cycle pulse: save_done arrived while busy (ignored)
// BEHAVIOUR
// - Reset: addr_q=0, ce0=0, m_data=0, m_valid=0, m_sof/m_eol/m_eof=0, busy=0, frame_drop=0; buffer emptied.
// - States: IDLE -> (save_done) FETCH -> (all LINES reads issued) DRAIN -> (m_eof accepted) IDLE.
// - IDLE: wait for save_done; on it set busy=1 next cycle, read pointer rd_line=0, enter FETCH.
// - FETCH: assert ce0 with addr_q=rd_line only when line buffer has a free slot counting reads in flight
//   (occupancy + in_flight < 2); rd_line increments per issued read; after issuing LINES-1 go DRAIN.
// - q0 captured exactly RD_LAT cycles after each ce0 into the buffer tail; no capture without a matching ce0.
// - Serializer: takes head line, beat index b=0..PIX_PER_LINE/BEAT_PIX-1; m_data = line[b*40 +: 40].
//   Beat advances only on m_valid & m_ready; m_valid/m_data/flags stable while m_valid & !m_ready.
//   On last beat accepted the head is popped; next line's beat 0 may be presented the following cycle.
// - Throughput: with m_ready held 1, after first-beat latency (save_done -> m_valid = 2+RD_LAT cycles)
//   one beat per cycle, no bubbles, frame = LINES*10 = 50000 beats.
// - Pixels passed unmodified (255 = no spike in window; 1..254 = window size).
// - save_done while busy: ignored, frame_drop pulses for one cycle; running frame unaffected.
// - save_done on the same cycle m_eof is accepted: treated as busy -> dropped (busy still 1 that cycle).
// - Reset mid-frame: all state to reset values next cycle, in-flight q0 discarded, no partial m_eof.
// - addr_q holds last issued address when ce0=0; never exceeds LINES-1.
// CONFIGURATION
// - RECON_STATS_EN defined: adds outputs stat_nospike[15:0] and stat_valid (1 bit). Counts accepted pixels
//   equal to 8'd255 within the frame (saturating at 16'hFFFF); on cycle after m_eof accepted, stat_valid
//   pulses 1 cycle with the final count; counter clears at start of next frame; reset value 0.
// - RECON_STATS_EN undefined: ports and counter absent; all other behaviour identical.
// TESTING
// - Memory model filled line n pixel i = (n+i)%254+1; save_done, m_ready=1 -> 50000 beats, first beat
//   m_data=0x0504030201 with m_sof=1, beat 9 m_eol=1, last beat m_eof=1 and line 4999 pixels 1..50 correct.
// - m_ready random 30% duty -> identical beat sequence; m_data held stable while stalled; ce0 never issued
//   when 2 lines buffered+in flight.
// - Second save_done at beat 100 -> frame_drop one pulse, frame completes with 50000 beats, busy falls after m_eof.
// - rst_200M asserted at line 2500 -> next cycle m_valid=0, busy=0, ce0=0; new save_done restarts at addr_q=0, m_sof=1.
// - RD_LAT=2 with m_ready=1 -> first m_valid 4 cycles after save_done, then no bubbles to m_eof.
// - RECON_STATS_EN, all pixels 255 except line 0 pixel 0=7 -> stat_valid pulse with stat_nospike=16'hFFFF
//   (249999 saturates); with LINES=10 -> stat_nospike=499.

Source files
------------

// File: rtl/recon_val_reader.sv
// Streams a reconstructed val frame out of the spike accumulator's read port as pixel beats.
// Optional RECON_STATS_EN adds a saturating per-frame count of no-spike (255) pixels.
module recon_val_reader #(
  parameter int unsigned LINES        = 5000,
  parameter int unsigned PIX_PER_LINE = 50,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned BEAT_PIX     = 5,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic                             clk_200M,
  input  logic                             rst_200M,
  input  logic                             save_done,
  output logic [12:0]                      addr_q,
  output logic                             ce0,
  input  logic [PIX_PER_LINE*PIX_W-1:0]    q0,
  output logic [BEAT_PIX*PIX_W-1:0]        m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_sof,
  output logic                             m_eol,
  output logic                             m_eof,
  output logic                             busy,
  output logic                             frame_drop
`ifdef RECON_STATS_EN
  ,
  output logic [15:0]                      stat_nospike,
  output logic                             stat_valid
`endif
);

  localparam int unsigned AW     = 13;
  localparam int unsigned LINE_W = PIX_PER_LINE * PIX_W;
  localparam int unsigned BEAT_W = BEAT_PIX * PIX_W;
  localparam int unsigned BEATS  = PIX_PER_LINE / BEAT_PIX;
  localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            r_state, w_state_d;
  logic              r_ce0;
  logic [AW-1:0]     r_addr, r_rd_line, r_out_line;
  logic [RD_LAT-1:0] r_lat;
  logic [LINE_W-1:0] r_buf [2];
  logic              r_head, r_tail;
  logic [1:0]        r_cnt;
  logic [BW-1:0]     r_beat;
  logic              r_busy, r_drop;

  logic              w_cap, w_valid, w_acc, w_pop, w_eof_acc, w_start;
  logic              w_last_beat, w_last_line, w_room, w_issue;
  logic [AW-1:0]     w_issue_addr;
  logic [2:0]        w_occ_next, w_infl;
  logic [LINE_W-1:0] w_head_line;
  logic [BEAT_W-1:0] w_beat_data;

  assign w_cap       = r_lat[RD_LAT-1];
  assign w_valid     = (r_cnt != 2'd0);
  assign w_head_line = r_buf[r_head];
  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  assign w_last_line = (r_out_line == AW'(LINES - 1));
  assign w_acc       = w_valid & m_ready;
  assign w_pop       = w_acc & w_last_beat;
  assign w_eof_acc   = w_pop & w_last_line;
  assign w_start     = (r_state == StIdle) & save_done;

  always_comb begin
    w_beat_data = '0;
    for (int k = 0; k < int'(BEATS); k++) begin
      if (r_beat == BW'(k)) w_beat_data = w_head_line[k*BEAT_W +: BEAT_W];
    end
  end

  // Slot accounting looks one cycle ahead so a freed slot is refilled without a bubble.
  always_comb begin
    w_occ_next = 3'(r_cnt) + 3'(w_cap) - 3'(w_pop);
    w_infl     = 3'(r_ce0);
    for (int i = 0; i < int'(RD_LAT) - 1; i++) w_infl = w_infl + 3'(r_lat[i]);
    w_room     = (w_occ_next + w_infl) < 3'd2;
  end

  always_comb begin
    w_state_d    = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_rd_line;
    unique case (r_state)
      StIdle: begin
        if (save_done) begin
          w_issue      = 1'b1;
          w_issue_addr = '0;
          w_state_d    = (LINES == 1) ? StDrain : StFetch;
        end
      end
      StFetch: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (r_rd_line == AW'(LINES - 1)) w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_eof_acc) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_200M) begin
    if (rst_200M) begin
      r_state    <= StIdle;
      r_ce0      <= 1'b0;
      r_addr     <= '0;
      r_rd_line  <= '0;
      r_lat      <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= 2'd0;
      r_beat     <= '0;
      r_out_line <= '0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ce0   <= w_issue;
      if (w_issue) begin
        r_addr    <= w_issue_addr;
        r_rd_line <= w_issue_addr + AW'(1);
      end
      r_lat[0] <= r_ce0;
      for (int i = 1; i < int'(RD_LAT); i++) r_lat[i] <= r_lat[i-1];
      if (w_cap) r_tail <= ~r_tail;
      r_cnt <= w_occ_next[1:0];
      if (w_acc) begin
        if (w_last_beat) begin
          r_beat     <= '0;
          r_head     <= ~r_head;
          r_out_line <= w_last_line ? '0 : r_out_line + AW'(1);
        end else begin
          r_beat <= r_beat + BW'(1);
        end
      end
      if (w_start)        r_busy <= 1'b1;
      else if (w_eof_acc) r_busy <= 1'b0;
      r_drop <= save_done & r_busy;
    end
  end

  // Line storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_200M) begin
    if (w_cap) r_buf[r_tail] <= q0;
  end

  assign addr_q     = r_addr;
  assign ce0        = r_ce0;
  assign m_valid    = w_valid;
  assign m_data     = w_valid ? w_beat_data : '0;
  assign m_sof      = w_valid & (r_out_line == '0) & (r_beat == '0);
  assign m_eol      = w_valid & w_last_beat;
  assign m_eof      = w_valid & w_last_beat & w_last_line;
  assign busy       = r_busy;
  assign frame_drop = r_drop;

`ifdef RECON_STATS_EN
  logic [15:0] r_stat;
  logic        r_stat_valid;
  logic [7:0]  w_n255;
  logic [16:0] w_stat_sum;

  always_comb begin
    w_n255 = 8'd0;
    for (int k = 0; k < int'(BEAT_PIX); k++) begin
      if (m_data[k*PIX_W +: PIX_W] == {PIX_W{1'b1}}) w_n255 = w_n255 + 8'd1;
    end
    w_stat_sum = {1'b0, r_stat} + 17'(w_n255);
  end

  always_ff @(posedge clk_200M) begin
    if (rst_200M) begin
      r_stat       <= 16'd0;
      r_stat_valid <= 1'b0;
    end else begin
      r_stat_valid <= w_eof_acc;
      if (w_start)    r_stat <= 16'd0;
      else if (w_acc) r_stat <= w_stat_sum[16] ? 16'hFFFF : w_stat_sum[15:0];
    end
  end

  assign stat_nospike = r_stat;
  assign stat_valid   = r_stat_valid;
`endif

endmodule

// File: tb/tb_recon_val_reader.sv
// Randomised bench for recon_val_reader: memory model, beat-queue reference and stall/flow checks.
module tb_recon_val_reader;

  localparam int unsigned LN    = 24;
  localparam int unsigned PPL   = 50;
  localparam int unsigned PW    = 8;
  localparam int unsigned BP    = 5;
  localparam int unsigned RL    = 1;
  localparam int unsigned BEATS = PPL / BP;
  localparam int unsigned LW    = PPL * PW;
  localparam int unsigned DW    = BP * PW;

  logic          clk_200M = 1'b0;
  logic          rst_200M = 1'b1;
  logic          save_done = 1'b0;
  logic          m_ready = 1'b1;
  logic [12:0]   addr_q;
  logic          ce0;
  logic [LW-1:0] q0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_sof, m_eol, m_eof, busy, frame_drop;
`ifdef RECON_STATS_EN
  logic [15:0]   stat_nospike;
  logic          stat_valid;
`endif

  recon_val_reader #(
    .LINES(LN), .PIX_PER_LINE(PPL), .PIX_W(PW), .BEAT_PIX(BP), .RD_LAT(RL)
  ) u_dut (
    .clk_200M   (clk_200M),
    .rst_200M   (rst_200M),
    .save_done  (save_done),
    .addr_q     (addr_q),
    .ce0        (ce0),
    .q0         (q0),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_eof      (m_eof),
    .busy       (busy),
`ifdef RECON_STATS_EN
    .stat_nospike(stat_nospike),
    .stat_valid (stat_valid),
`endif
    .frame_drop (frame_drop)
  );

  always #5 clk_200M = ~clk_200M;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: line n pixel i = (n+i+seed)%254+1, or the all-255 pattern.
  int unsigned seed_q = 0;
  bit          all255 = 1'b0;

  function automatic logic [7:0] pix(int n, int i);
    if (all255) return (n == 0 && i == 0) ? 8'd7 : 8'd255;
    return 8'((n + i + int'(seed_q)) % 254 + 1);
  endfunction

  function automatic logic [LW-1:0] line_data(int n);
    logic [LW-1:0] r;
    for (int i = 0; i < int'(PPL); i++) r[i*PW +: PW] = pix(n, i);
    return r;
  endfunction

  function automatic logic [LW-1:0] junk();
    logic [LW-1:0] r;
    for (int i = 0; i < int'(LW); i++) r[i] = 1'($urandom);
    return r;
  endfunction

  logic [LW-1:0] pipe [RL];
  always @(posedge clk_200M) begin
    pipe[0] <= ce0 ? line_data(int'(addr_q)) : junk();
    for (int k = 1; k < int'(RL); k++) pipe[k] <= pipe[k-1];
  end
  assign q0 = pipe[RL-1];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
  } beat_t;

  beat_t exp_q[$];

  task automatic build_expect();
    beat_t e;
    exp_q.delete();
    for (int n = 0; n < int'(LN); n++) begin
      for (int b = 0; b < int'(BEATS); b++) begin
        for (int p = 0; p < int'(BP); p++) e.d[p*PW +: PW] = pix(n, b * int'(BP) + p);
        e.sof = (n == 0 && b == 0);
        e.eol = (b == int'(BEATS) - 1);
        e.eof = e.eol && (n == int'(LN) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  bit          mon_en = 1'b0;
  bit          bubble_chk = 1'b0;
  bit          eof_seen, first_seen, prev_stall;
  beat_t       prev_beat;
  int          beats_seen, lines_done, issued, drop_cnt, stat_pulses;
  logic [15:0] exp_stat;

  task automatic mon_reset();
    eof_seen = 0; first_seen = 0; prev_stall = 0; prev_beat = '0;
    beats_seen = 0; lines_done = 0; issued = 0; drop_cnt = 0; stat_pulses = 0;
    exp_stat = 16'd0;
  endtask

  always @(negedge clk_200M) begin
    beat_t e;
    beat_t cur;
    if (mon_en) begin
      cur = {m_data, m_sof, m_eol, m_eof};
      if (frame_drop) drop_cnt++;
      if (ce0) begin
        check_eq("ce0_addr", 64'(addr_q), 64'(issued));
        check_eq("ce0_room", 64'((issued - lines_done) < 2), 64'(1));
        issued++;
      end
      if (prev_stall) begin
        check_eq("stall_valid", 64'(m_valid), 64'(1));
        check_eq("stall_hold", 64'(cur), 64'(prev_beat));
      end
      if (bubble_chk && first_seen && !eof_seen) check_eq("no_bubble", 64'(m_valid), 64'(1));
      if (m_valid) first_seen = 1;
      if (m_valid && m_ready) begin
        check_eq("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("beat", 64'(cur), 64'(e));
          for (int p = 0; p < int'(BP); p++)
            if (e.d[p*PW +: PW] == 8'd255 && exp_stat != 16'hFFFF) exp_stat = exp_stat + 16'd1;
          if (e.eol) lines_done++;
          if (e.eof) eof_seen = 1;
        end
        beats_seen++;
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = cur;
`ifdef RECON_STATS_EN
      if (stat_valid) begin
        check_eq("stat_nospike", 64'(stat_nospike), 64'(exp_stat));
        stat_pulses++;
      end
`endif
    end
  end

  task automatic pulse_save();
    @(posedge clk_200M); #1 save_done = 1'b1;
    @(posedge clk_200M); #1 save_done = 1'b0;
  endtask

  // Runs the sink until m_eof is accepted or stop_at beats have gone by (0 = run to end).
  task automatic run_to_eof(input bit rnd, input bit inject, input int stop_at);
    int n;
    bit injected;
    n = 0;
    injected = 0;
    while (!eof_seen && n < 5000 && !(stop_at > 0 && beats_seen >= stop_at)) begin
      @(posedge clk_200M); #1;
      m_ready   = rnd ? ($urandom_range(99) < 30) : 1'b1;
      save_done = inject && !injected && beats_seen >= 100;
      if (save_done) injected = 1;
      n++;
    end
    save_done = 1'b0;
    check_eq("run_in_budget", 64'(n < 5000), 64'(1));
  endtask

  task automatic frame_end_checks(input int drops);
    check_eq("busy_clear", 64'(busy), 64'(0));
    repeat (3) @(negedge clk_200M);
    check_eq("beat_count", 64'(beats_seen), 64'(LN * BEATS));
    check_eq("reads_issued", 64'(issued), 64'(LN));
    check_eq("queue_empty", 64'(exp_q.size()), 64'(0));
    check_eq("drop_count", 64'(drop_cnt), 64'(drops));
`ifdef RECON_STATS_EN
    check_eq("stat_pulses", 64'(stat_pulses), 64'(1));
`endif
  endtask

  initial begin
    int lat;
    mon_reset();
    repeat (3) @(posedge clk_200M);
    #1;
    check_eq("rst_addr", 64'(addr_q), 64'(0));
    check_eq("rst_ce0", 64'(ce0), 64'(0));
    check_eq("rst_valid", 64'(m_valid), 64'(0));
    check_eq("rst_data", 64'(m_data), 64'(0));
    check_eq("rst_flags", 64'({m_sof, m_eol, m_eof}), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_drop", 64'(frame_drop), 64'(0));
    rst_200M = 1'b0;

    // Frame A: full-rate sink, reference pattern, first-beat latency.
    seed_q = 0; all255 = 0; build_expect(); mon_reset();
    mon_en = 1; bubble_chk = 1; m_ready = 1'b1;
    pulse_save();
    lat = 1;
    @(negedge clk_200M);
    check_eq("busy_set", 64'(busy), 64'(1));
    while (!m_valid && lat < 20) begin
      @(negedge clk_200M);
      lat++;
    end
    check_eq("first_latency", 64'(lat), 64'(2 + RL));
    check_eq("first_data", 64'(m_data), 64'h05_0403_0201);
    check_eq("first_sof", 64'(m_sof), 64'(1));
    run_to_eof(0, 0, 0);
    frame_end_checks(0);
    bubble_chk = 0;

    // Frame B: 30% sink duty plus a save_done arriving mid-frame.
    seed_q = $urandom_range(253); build_expect(); mon_reset();
    pulse_save();
    run_to_eof(1, 1, 0);
    frame_end_checks(1);

    // Frame C: reset in the middle of the frame.
    seed_q = $urandom_range(253); build_expect(); mon_reset();
    m_ready = 1'b1;
    pulse_save();
    run_to_eof(0, 0, (LN / 2) * BEATS);
    mon_en = 0;
    rst_200M = 1'b1;
    @(posedge clk_200M); #1;
    check_eq("midrst_valid", 64'(m_valid), 64'(0));
    check_eq("midrst_busy", 64'(busy), 64'(0));
    check_eq("midrst_ce0", 64'(ce0), 64'(0));
    check_eq("midrst_eof", 64'(m_eof), 64'(0));
    rst_200M = 1'b0;
    repeat (2) @(posedge clk_200M);

    // Frame D: restart after reset, random sink.
    seed_q = $urandom_range(253); build_expect(); mon_reset();
    mon_en = 1;
    pulse_save();
    run_to_eof(1, 0, 0);
    frame_end_checks(0);

    // Frame E: mostly no-spike pixels.
    all255 = 1; build_expect(); mon_reset();
    pulse_save();
    run_to_eof(1, 0, 0);
    frame_end_checks(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
